// File: rtl/prime_uart_tx_if.sv
// prime_uart_tx_if
//   Valid/ready handshake that carries one unsigned value to the UART printer.
//   Signals:
//     valid  producer has a value on data
//     data   W-bit unsigned value, sampled by the consumer only on accept
//     ready  consumer is idle and will accept on the next edge with valid high
//   Modports: master (producer side), slave (printer side).
interface prime_uart_tx_if #(
    parameter int W = 16
);
    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prime_uart_tx.sv
// prime_uart_tx
//   Takes one W-bit unsigned value per handshake, converts it to decimal by
//   repeated subtraction, and transmits the digits (leading zeros suppressed)
//   followed by CR LF as back-to-back UART frames.
//   Ports:
//     clk      clock
//     rst      synchronous reset, active-high
//     up_if    slave side of prime_uart_tx_if (valid, data in; ready out)
//     tx_o     UART line, idle high
//     busy_o   conversion or transmission in progress
//   Build option: define PRIME_UART_TX_PARITY_EN for 8E1 frames (even parity
//   bit between data bit 7 and stop); default is 8N1.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a value (ready high once out of reset)
//   CONV   | one compare/subtract per clk, digit idx_q, MSB digit first
//   SEND   | digit idx_q is the next character to load into the framer
//   CR     | CR is the next character to load
//   LF     | LF pending (lf_q=0) or on the line (lf_q=1)
module prime_uart_tx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200,
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst,
    prime_uart_tx_if.slave up_if,
    output logic           tx_o,
    output logic           busy_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int DW  = $clog2(DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef PRIME_UART_TX_PARITY_EN
    localparam int FW  = 11;
`else
    localparam int FW  = 10;
`endif

    function automatic logic [DIGITS-1:0][63:0] pow_table();
        logic [DIGITS-1:0][63:0] t;
        logic [63:0]             p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            t[i] = p;
            p    = p * 64'd10;
        end
        return t;
    endfunction

    localparam logic [DIGITS-1:0][63:0] POW = pow_table();

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_SEND, S_CR, S_LF} state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            rem_q, rem_d;
    logic [DIGITS-1:0][3:0]  bcd_q, bcd_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    lf_q, lf_d;
    logic                    started_q;
    logic                    active_q, active_d;
    logic [FW-1:0]           shift_q, shift_d;
    logic [3:0]              bits_q, bits_d;
    logic [DW-1:0]           baud_q, baud_d;

    logic                    avail;
    logic                    take;
    logic                    frame_end;
    logic [7:0]              ch;
    logic [FW-1:0]           frame;
    logic [IW-1:0]           lead;

    assign up_if.ready = started_q && (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign tx_o        = active_q ? shift_q[0] : 1'b1;

    // Highest non-zero digit; 0 when every digit is zero so "0" still prints.
    always_comb begin
        lead = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i] != 4'd0) lead = IW'(i);
        end
    end

    // Next character offered to the framer.
    always_comb begin
        avail = 1'b0;
        ch    = 8'h00;
        case (state_q)
            S_SEND: begin
                avail = 1'b1;
                ch    = 8'h30 + {4'h0, bcd_q[idx_q]};
            end
            S_CR: begin
                avail = 1'b1;
                ch    = 8'h0D;
            end
            S_LF: begin
                avail = !lf_q;
                ch    = 8'h0A;
            end
            default: ;
        endcase
`ifdef PRIME_UART_TX_PARITY_EN
        frame = {1'b1, ^ch, ch, 1'b0};
`else
        frame = {1'b1, ch, 1'b0};
`endif
    end

    // Loading in the stop bit's last clk keeps characters back-to-back.
    assign frame_end = active_q && (baud_q == '0) && (bits_q == '0);
    assign take      = avail && (!active_q || frame_end);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        bcd_d   = bcd_q;
        idx_d   = idx_q;
        lf_d    = lf_q;
        case (state_q)
            S_IDLE: begin
                if (up_if.valid && up_if.ready) begin
                    rem_d   = up_if.data;
                    bcd_d   = '0;
                    idx_d   = IW'(DIGITS - 1);
                    lf_d    = 1'b0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (64'(rem_q) >= POW[idx_q]) begin
                    rem_d        = rem_q - POW[idx_q][W-1:0];
                    bcd_d[idx_q] = bcd_q[idx_q] + 4'd1;
                end else if (idx_q == '0) begin
                    idx_d   = lead;
                    state_d = S_SEND;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_SEND: begin
                if (take) begin
                    if (idx_q == '0) state_d = S_CR;
                    else             idx_d   = idx_q - 1'b1;
                end
            end
            S_CR: begin
                if (take) state_d = S_LF;
            end
            S_LF: begin
                if (take)                  lf_d    = 1'b1;
                else if (lf_q && frame_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Framer: shift register, bit down-counter, baud down-counter.
    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        bits_d   = bits_q;
        baud_d   = baud_q;
        if (take) begin
            shift_d  = frame;
            bits_d   = 4'(FW - 1);
            baud_d   = DW'(DIV - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (baud_q == '0) begin
                if (bits_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    shift_d = {1'b1, shift_q[FW-1:1]};
                    bits_d  = bits_q - 4'd1;
                    baud_d  = DW'(DIV - 1);
                end
            end else begin
                baud_d = baud_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            bcd_q     <= '0;
            idx_q     <= '0;
            lf_q      <= 1'b0;
            started_q <= 1'b0;
            active_q  <= 1'b0;
            shift_q   <= '0;
            bits_q    <= '0;
            baud_q    <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            bcd_q     <= bcd_d;
            idx_q     <= idx_d;
            lf_q      <= lf_d;
            started_q <= 1'b1;
            active_q  <= active_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
            baud_q    <= baud_d;
        end
    end
endmodule

// File: tb/tb_prime_uart_tx.sv
// tb_prime_uart_tx
//   Drives values into prime_uart_tx, decodes tx at bit centres and compares
//   against the decimal string of each value followed by CR LF.
module tb_prime_uart_tx;
    localparam int DIV    = 12000000 / 115200;
    localparam int DIGITS = 5;
`ifdef PRIME_UART_TX_PARITY_EN
    localparam int FW = 11;
`else
    localparam int FW = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    prime_uart_tx_if #(.W(16)) u_if ();

    prime_uart_tx #(
        .CLK_HZ(12000000),
        .BAUD  (115200),
        .W     (16),
        .DIGITS(DIGITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .up_if (u_if),
        .tx_o  (tx),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered on the negedge right after the start bit began; leaves on the
    // negedge one full frame later (next start bit or idle).
    task automatic rx_char(input logic [7:0] expb, input bit last);
        logic [7:0] b;
        repeat (DIV / 2) @(negedge clk);
        chk("start_mid", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = tx;
        end
        chk("byte", b, expb);
`ifdef PRIME_UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        chk("parity", tx, ^expb);
`endif
        repeat (DIV) @(negedge clk);
        chk("stop", tx, 1'b1);
        repeat (DIV - DIV / 2 - 1) @(negedge clk);
        if (last) chk("ready_before_end", u_if.ready, 1'b0);
        else      chk("stop_tail", tx, 1'b1);
        @(negedge clk);
        if (last) begin
            chk("ready_after_lf", u_if.ready, 1'b1);
            chk("busy_after_lf", busy, 1'b0);
            chk("idle_tx", tx, 1'b1);
        end else begin
            chk("b2b_start", tx, 1'b0);
        end
    endtask

    task automatic accept_and_wait_start(input int v, output bit ok);
        int n;
        int acc;
        ok = 1'b0;
        n = 0;
        while (u_if.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (u_if.ready !== 1'b1) begin
            chk("ready_wait", u_if.ready, 1'b1);
            return;
        end
        u_if.valid = 1'b1;
        u_if.data  = v[15:0];
        @(posedge clk);
        @(negedge clk);
        u_if.valid = 1'b0;
        u_if.data  = 16'($urandom);
        acc = cyc;
        chk("busy_on_accept", busy, 1'b1);
        chk("ready_on_accept", u_if.ready, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            chk("start_timeout", tx, 1'b0);
            return;
        end
        chk("latency_ok", 32'((cyc - acc) <= DIGITS * 10 + 2), 32'd1);
        ok = 1'b1;
    endtask

    task automatic run_value(input int v, input bit spam);
        string      s;
        logic [7:0] q[$];
        bit         ok;
        int         lows;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        accept_and_wait_start(v, ok);
        if (!ok) return;
        if (spam) begin
            fork
                begin
                    repeat (3 * DIV) @(negedge clk);
                    u_if.valid = 1'b1;
                    u_if.data  = 16'd7;
                    repeat (4) @(negedge clk);
                    u_if.valid = 1'b0;
                end
            join_none
        end
        for (int i = 0; i < q.size(); i++) rx_char(q[i], i == q.size() - 1);
        if (spam) begin
            lows = 0;
            repeat (3 * FW * DIV) begin
                @(negedge clk);
                if (tx !== 1'b1) lows++;
            end
            chk("spam_ignored", lows, 0);
        end
    endtask

    task automatic reset_midway();
        bit ok;
        int lows;
        accept_and_wait_start(65521, ok);
        if (!ok) return;
        // into data bit 2 of the second character ('5')
        repeat (FW * DIV + DIV / 2 + 3 * DIV) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", u_if.ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", u_if.ready, 1'b1);
        lows = 0;
        repeat (2 * FW * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("idle_after_rst", lows, 0);
    endtask

    initial begin
        rst        = 1'b1;
        u_if.valid = 1'b0;
        u_if.data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_ready", u_if.ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", u_if.ready, 1'b1);

        run_value(0, 1'b0);
        run_value(2, 1'b0);
        run_value(65521, 1'b1);
        run_value(65535, 1'b0);
        reset_midway();
        run_value(7, 1'b0);
        for (int k = 0; k < 4; k++) run_value(int'($urandom_range(0, 65535)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
